ecc_53_err_monitor: RTL
=======================

Name: ecc_53_err_monitor

Overview:
Registered stage directly downstream of the 53-bit ECC fault-detect stage on the FIFO read path.
- Registers the corrected read word and its per-read error flags.
- Keeps saturating sbit/dbit/fault event counters.
- Captures the address and type of the most severe error seen.
- Raises a level interrupt until software clears it.

Parameters:
DATA_WIDTH, 53, width of corrected data word
ADDR_WIDTH, 8, FIFO read address width
CNT_WIDTH, 16, width of each event counter
SBIT_THRESH, 16, sbit count at which irq asserts (1 to 2^CNT_WIDTH-1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
rd_vld  input  1  read word present this cycle; qualifies all inputs below
rd_addr  input  ADDR_WIDTH  FIFO address of the read word
data_in  input  DATA_WIDTH  data from fault-detect stage
sbit_err  input  1  single-bit error corrected
dbit_err  input  1  uncorrectable double-bit error
ecc_fault  input  1  ECC logic self-check mismatch
clr  input  1  single-cycle pulse: clears counters, capture and irq
out_vld  output  1  registered rd_vld
out_data  output  DATA_WIDTH  registered data
out_err  output  1  registered (dbit_err | ecc_fault); data unusable
sbit_cnt  output  CNT_WIDTH  saturating sbit event count
dbit_cnt  output  CNT_WIDTH  saturating dbit event count
fault_cnt  output  CNT_WIDTH  saturating ecc_fault event count
err_addr  output  ADDR_WIDTH  captured error address
err_type  output  2  captured type: 00 none, 01 sbit, 10 dbit, 11 fault
irq  output  1  level interrupt

Behaviour:
Reset and qualification:
- All outputs and internal state reset to 0 on rst_n low, asynchronously.
- Reset mid-stream discards the in-flight word.
- All error inputs are ignored when rd_vld=0.
Data path:
- Latency 1 cycle. out_vld, out_data, out_err are registered every cycle from rd_vld and the inputs.
- out_data is loaded only when rd_vld=1 and holds otherwise.
- No backpressure.
Counters:
- Each counter increments by 1 per qualified cycle with its flag set.
- Flags set together in the same cycle each count (e.g. dbit+fault increments both).
- Saturate at all-ones; no wrap.
Capture FSM, states CAP_IDLE, CAP_SOFT, CAP_HARD:
- CAP_IDLE -> CAP_SOFT on qualified sbit only; load err_addr, err_type=01.
- CAP_IDLE or CAP_SOFT -> CAP_HARD on qualified dbit or fault; load err_addr.
  - err_type=11 if ecc_fault is set (fault outranks dbit), otherwise 10.
- CAP_SOFT ignores further sbit events.
- CAP_HARD ignores all further events until clr.
irq:
- Set on a qualified dbit or fault.
- Set when sbit_cnt transitions to SBIT_THRESH, or saturates at or above it.
- Sticky until clr.
clr:
- Next cycle: counters=0, FSM=CAP_IDLE, err_type=00, err_addr=0, irq=0.
- If a qualified event coincides with clr, it is applied on top of the cleared state. Example: clr with dbit gives dbit_cnt=1, CAP_HARD, irq=1.
- clr does not affect the data path.

Optional Feature:
ECC_MON_POISON_EN
- Defined: when out_err is asserted, out_data is forced to all-ones (poison pattern) instead of data_in.
- Undefined: out_data always carries registered data_in; consumers must use out_err.

Decomposition:
- Package ecc_mon_pkg:
  - err_type encoding constants (ERR_NONE, ERR_SBIT, ERR_DBIT, ERR_FAULT).
  - Capture FSM state encoding.
  - Poison pattern constant.
- One sub-module, ecc_sat_cnt (parameter WIDTH; inputs inc, clr; output cnt; saturating), instantiated three times.

Test Plan:
1. Reset then rd_vld=1, addr 0x05, data 0x1F_FFFF_FFFF_FFFF, no flags -> next cycle out_vld=1, data matches, out_err=0, all counters 0, irq=0.
2. 16 qualified sbit reads at addrs 0x10..0x1F -> err_addr=0x10, err_type=01, sbit_cnt=16, irq rises in the cycle after the 16th read.
3. sbit at 0x20, then dbit at 0x21, then fault at 0x22 -> err_type 01 then 10; stays 10 with err_addr=0x21 after the fault; fault_cnt=1, irq=1.
4. dbit+fault together at 0x30 -> dbit_cnt=1, fault_cnt=1, err_type=11, err_addr=0x30, out_err=1; out_data all-ones only with ECC_MON_POISON_EN.
5. Force sbit for 2^CNT_WIDTH+3 cycles -> sbit_cnt holds 0xFFFF, no wrap.
6. clr coincident with qualified dbit at 0x40 -> dbit_cnt=1, sbit_cnt=0, err_type=10, err_addr=0x40, irq=1.
7. rst_n low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/ecc_mon_pkg.sv
// ecc_mon_pkg
// Shared definitions for the ECC read-path error monitor.
//   - err_type encodings reported on err_type
//   - capture FSM state encoding
//   - poison pattern substituted for unusable data when ECC_MON_POISON_EN is defined
package ecc_mon_pkg;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_SBIT  = 2'b01;
    localparam logic [1:0] ERR_DBIT  = 2'b10;
    localparam logic [1:0] ERR_FAULT = 2'b11;

    typedef enum logic [1:0] {
        CAP_IDLE = 2'b00,
        CAP_SOFT = 2'b01,
        CAP_HARD = 2'b10
    } cap_state_e;

    // Wide enough for any supported data width; the top slices the low bits.
    localparam logic [63:0] POISON_PATTERN = '1;

endpackage

// File: rtl/ecc_sat_cnt.sv
// ecc_sat_cnt
// Saturating event counter with synchronous clear.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   inc        : count one event this cycle
//   clr        : zero the count; an inc in the same cycle counts on top of zero
//   cnt        : current count, sticks at all-ones
module ecc_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] base;

    always_comb begin
        base  = clr ? '0 : cnt_q;
        cnt_d = base;
        if (inc && (base != '1)) begin
            cnt_d = base + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ecc_53_err_monitor.sv
// ecc_53_err_monitor
// Registered stage behind the 53-bit ECC fault-detect stage on the FIFO read
// path. Registers the corrected word and its error flag, counts sbit/dbit/fault
// events with saturating counters, captures the address and type of the most
// severe error, and raises a sticky interrupt until clr.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   rd_vld, rd_addr, data_in   : read word and its FIFO address
//   sbit_err, dbit_err, ecc_fault : per-read error flags (qualified by rd_vld)
//   clr                        : pulse clearing counters, capture and irq
//   out_vld, out_data, out_err : registered read word, 1-cycle latency
//   sbit_cnt, dbit_cnt, fault_cnt : saturating event counts
//   err_addr, err_type         : captured most-severe error
//   irq                        : level interrupt
// Build option: ECC_MON_POISON_EN forces out_data to all-ones when out_err is set.
module ecc_53_err_monitor
    import ecc_mon_pkg::*;
#(
    parameter int DATA_WIDTH  = 53,
    parameter int ADDR_WIDTH  = 8,
    parameter int CNT_WIDTH   = 16,
    parameter int SBIT_THRESH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_vld,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  sbit_err,
    input  logic                  dbit_err,
    input  logic                  ecc_fault,
    input  logic                  clr,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_err,
    output logic [CNT_WIDTH-1:0]  sbit_cnt,
    output logic [CNT_WIDTH-1:0]  dbit_cnt,
    output logic [CNT_WIDTH-1:0]  fault_cnt,
    output logic [ADDR_WIDTH-1:0] err_addr,
    output logic [1:0]            err_type,
    output logic                  irq
);

    // Threshold minus one: an sbit increment starting from here or above
    // lands at/above the threshold (saturation included).
    localparam logic [CNT_WIDTH-1:0] THRESH_M1 = CNT_WIDTH'(SBIT_THRESH - 1);

    logic                  sbit_q_evt;
    logic                  dbit_q_evt;
    logic                  fault_q_evt;
    logic                  hard_evt;
    logic                  sbit_thr_hit;

    logic                  out_vld_q,  out_vld_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_err_q,  out_err_d;
    cap_state_e            state_q,    state_d;
    logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
    logic [1:0]            err_type_q, err_type_d;
    logic                  irq_q,      irq_d;

    cap_state_e            state_base;
    logic [CNT_WIDTH-1:0]  sbit_base;

    assign sbit_q_evt  = rd_vld & sbit_err;
    assign dbit_q_evt  = rd_vld & dbit_err;
    assign fault_q_evt = rd_vld & ecc_fault;
    assign hard_evt    = dbit_q_evt | fault_q_evt;

    ecc_sat_cnt #(.WIDTH(CNT_WIDTH)) u_sbit_cnt (
        .clk(clk), .rst_n(rst_n), .inc(sbit_q_evt),  .clr(clr), .cnt(sbit_cnt)
    );
    ecc_sat_cnt #(.WIDTH(CNT_WIDTH)) u_dbit_cnt (
        .clk(clk), .rst_n(rst_n), .inc(dbit_q_evt),  .clr(clr), .cnt(dbit_cnt)
    );
    ecc_sat_cnt #(.WIDTH(CNT_WIDTH)) u_fault_cnt (
        .clk(clk), .rst_n(rst_n), .inc(fault_q_evt), .clr(clr), .cnt(fault_cnt)
    );

    // Data path: independent of clr.
    always_comb begin
        out_vld_d  = rd_vld;
        out_err_d  = hard_evt;
        out_data_d = out_data_q;
        if (rd_vld) begin
`ifdef ECC_MON_POISON_EN
            out_data_d = hard_evt ? POISON_PATTERN[DATA_WIDTH-1:0] : data_in;
`else
            out_data_d = data_in;
`endif
        end
    end

    // Capture FSM and irq. clr produces a cleared base state; any qualified
    // event this cycle is then applied on top of that base.
    always_comb begin
        state_base   = clr ? CAP_IDLE : state_q;
        sbit_base    = clr ? '0 : sbit_cnt;
        state_d      = state_base;
        err_addr_d   = clr ? '0 : err_addr_q;
        err_type_d   = clr ? ERR_NONE : err_type_q;
        sbit_thr_hit = sbit_q_evt && (sbit_base >= THRESH_M1);
        irq_d        = (clr ? 1'b0 : irq_q) | hard_evt | sbit_thr_hit;

        if (state_base != CAP_HARD) begin
            if (hard_evt) begin
                state_d    = CAP_HARD;
                err_addr_d = rd_addr;
                err_type_d = fault_q_evt ? ERR_FAULT : ERR_DBIT;
            end else if (sbit_q_evt && (state_base == CAP_IDLE)) begin
                state_d    = CAP_SOFT;
                err_addr_d = rd_addr;
                err_type_d = ERR_SBIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
            state_q    <= CAP_IDLE;
            err_addr_q <= '0;
            err_type_q <= ERR_NONE;
            irq_q      <= 1'b0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
            state_q    <= state_d;
            err_addr_q <= err_addr_d;
            err_type_q <= err_type_d;
            irq_q      <= irq_d;
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_err  = out_err_q;
    assign err_addr = err_addr_q;
    assign err_type = err_type_q;
    assign irq      = irq_q;

endmodule
